router_pkt_ctrl: RTL and testbench

- Packet input controller of the 1x3 router; sits directly upstream of the three per-destination FIFOs.
- Accepts a byte stream from the source, decodes the header, and steers header, payload and parity bytes into the selected FIFO.
- Drives the FIFO write enables and `lfd_state`, back-pressures the source when the target FIFO is full, and checks packet parity.

---
 rtl/router_pkt_ctrl.sv | 168 ++++++++++++++++
 tb/tb_router_pkt_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_ctrl.sv
// Packet input controller for the 1x3 router.
// Decodes the header byte, steers header/payload/parity bytes into the
// selected destination FIFO with zero latency, back-pressures on FIFO full,
// and checks packet parity.
// Optional statistics counters are built when ROUTER_PKT_STATS_EN is defined;
// otherwise pkt_count/err_count are tied to zero.
//
// state       | meaning
// ------------+--------------------------------------------------------
// IDLE        | waiting for a header byte
// LOAD_DATA   | forwarding payload bytes, rem bytes still to come
// LOAD_PARITY | waiting for the parity byte
// CHECK       | one-cycle bubble after parity, source held off
// DROP        | consuming a packet with an invalid destination
module router_pkt_ctrl #(
  parameter int DATA_W   = 8,
  parameter int NUM_DEST = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pkt_valid,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [NUM_DEST-1:0] fifo_full,
  output logic                busy,
  output logic [NUM_DEST-1:0] wr_en,
  output logic [DATA_W-1:0]   dout,
  output logic                lfd_state,
  output logic                pkt_done,
  output logic                parity_err,
  output logic                drop_err,
  output logic [15:0]         pkt_count,
  output logic [15:0]         err_count
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_LOAD_DATA   = 3'd1;
  localparam logic [2:0] S_LOAD_PARITY = 3'd2;
  localparam logic [2:0] S_CHECK       = 3'd3;
  localparam logic [2:0] S_DROP        = 3'd4;

  localparam logic [2:0] NUM_DEST_L = 3'(NUM_DEST);

  logic [2:0]        state;
  logic [1:0]        dest_q;
  logic [5:0]        rem;
  logic [DATA_W-1:0] par;

  logic [1:0] dest_cur;
  logic       dest_valid;
  logic       full_sel;
  logic       load;
  logic       accept;

  assign dout = data_in;

  // Destination select, back-pressure and zero-latency write enables
  always_comb begin
    dest_cur   = (state == S_IDLE) ? data_in[1:0] : dest_q;
    dest_valid = ({1'b0, data_in[1:0]} < NUM_DEST_L);
    full_sel   = 1'b0;
    for (int i = 0; i < NUM_DEST; i++) begin
      if (dest_cur == 2'(i)) full_sel = fifo_full[i];
    end
    busy = 1'b0;
    load = 1'b0;
    case (state)
      S_IDLE: begin
        busy = pkt_valid & dest_valid & full_sel;
        load = dest_valid;
      end
      S_LOAD_DATA, S_LOAD_PARITY: begin
        busy = full_sel;
        load = 1'b1;
      end
      S_CHECK: busy = 1'b1;
      default: busy = 1'b0;
    endcase
    accept = pkt_valid & ~busy;
    wr_en  = '0;
    for (int i = 0; i < NUM_DEST; i++) begin
      wr_en[i] = accept & load & (dest_cur == 2'(i));
    end
    lfd_state = accept & (state == S_IDLE) & dest_valid;
  end

  // Packet sequencing; result flags and pkt_done update on the edge that
  // takes the final byte so they are visible together in the following cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      dest_q     <= '0;
      rem        <= '0;
      par        <= '0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            rem <= data_in[7:2];
            if (dest_valid) begin
              dest_q <= data_in[1:0];
              par    <= data_in;
              state  <= (data_in[7:2] != 6'd0) ? S_LOAD_DATA : S_LOAD_PARITY;
            end else begin
              state <= S_DROP;
            end
          end
        end
        S_LOAD_DATA: begin
          if (accept) begin
            par <= par ^ data_in;
            rem <= rem - 6'd1;
            if (rem == 6'd1) state <= S_LOAD_PARITY;
          end
        end
        S_LOAD_PARITY: begin
          if (accept) begin
            parity_err <= (par != data_in);
            drop_err   <= 1'b0;
            pkt_done   <= 1'b1;
            state      <= S_CHECK;
          end
        end
        S_CHECK: state <= S_IDLE;
        S_DROP: begin
          if (accept) begin
            if (rem == 6'd0) begin
              drop_err   <= 1'b1;
              parity_err <= 1'b0;
              pkt_done   <= 1'b1;
              state      <= S_IDLE;
            end else begin
              rem <= rem - 6'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ROUTER_PKT_STATS_EN
  logic done_good;
  logic done_bad;

  assign done_good = accept & (state == S_LOAD_PARITY) & (par == data_in);
  assign done_bad  = accept & (((state == S_LOAD_PARITY) & (par != data_in)) |
                               ((state == S_DROP) & (rem == 6'd0)));

  // Saturating good/error packet counters
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      if (done_good && pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
      if (done_bad && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end
`else
  assign pkt_count = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Self-checking bench for router_pkt_ctrl: directed packets from the test
// plan followed by randomized packets with random gaps and FIFO-full stalls,
// checked against a packet-level reference model.
module tb_router_pkt_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_req = 1'b1;
  logic        pkt_valid = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [2:0]  fifo_full = 3'b000;
  logic        busy;
  logic [2:0]  wr_en;
  logic [7:0]  dout;
  logic        lfd_state;
  logic        pkt_done;
  logic        parity_err;
  logic        drop_err;
  logic [15:0] pkt_count;
  logic [15:0] err_count;

  router_pkt_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .pkt_valid  (pkt_valid),
    .data_in    (data_in),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .wr_en      (wr_en),
    .dout       (dout),
    .lfd_state  (lfd_state),
    .pkt_done   (pkt_done),
    .parity_err (parity_err),
    .drop_err   (drop_err),
    .pkt_count  (pkt_count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         d;
    logic [7:0] b;
  } wr_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] pkt_q[$];
  wr_t        wr_log[$];
  int         cyc_n = 0;
  int         last_acc = 0;
  int         done_n = 0;
  int         done_at = 0;
  int         lfd_n = 0;
  int         oh_viol = 0;
  logic       done_perr = 1'b0;
  logic       done_derr = 1'b0;
  logic       acc = 1'b0;
  logic [7:0] lfd_byte = 8'h00;
  int         exp_good = 0;
  int         exp_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, observe 1ns later, edge follows.
  task automatic cyc(input logic v, input logic [7:0] d, input logic [2:0] f);
    wr_t w;
    @(negedge clk);
    rst       = rst_req;
    pkt_valid = v;
    data_in   = d;
    fifo_full = f;
    #1;
    cyc_n++;
    if (pkt_done) begin
      done_n++;
      done_at   = cyc_n;
      done_perr = parity_err;
      done_derr = drop_err;
    end
    if ($countones(wr_en) > 1) oh_viol++;
    for (int i = 0; i < 3; i++) begin
      if (wr_en[i]) begin
        w.d = i;
        w.b = dout;
        wr_log.push_back(w);
      end
    end
    if (lfd_state) begin
      lfd_n++;
      lfd_byte = dout;
    end
    acc = v & ~busy & ~rst;
    if (acc) last_acc = cyc_n;
  endtask

  task automatic clear_mon();
    wr_log.delete();
    done_n  = 0;
    lfd_n   = 0;
    oh_viol = 0;
    done_at = -1;
  endtask

  task automatic gen_pkt(input int dst, input int len, input bit bad);
    logic [7:0] x;
    logic [7:0] b;
    pkt_q.delete();
    x = {6'(len), 2'(dst)};
    pkt_q.push_back(x);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      pkt_q.push_back(b);
      x = x ^ b;
    end
    if (bad) x = x ^ (8'h01 << $urandom_range(7));
    pkt_q.push_back(x);
  endtask

  // Packet-level model: route, parity and error flags from the byte list.
  task automatic verify();
    int         n;
    int         mism;
    int         dst;
    bit         vd;
    bit         perr;
    logic [7:0] x;
    logic [7:0] hdr;
    repeat (3) cyc(1'b0, 8'h00, 3'b000);
    n    = pkt_q.size();
    hdr  = pkt_q[0];
    dst  = int'(hdr[1:0]);
    vd   = (dst < 3);
    x    = 8'h00;
    for (int i = 0; i < n - 1; i++) x = x ^ pkt_q[i];
    perr = vd && (x != pkt_q[n-1]);
    chk("wr_count", wr_log.size(), vd ? n : 0);
    mism = 0;
    for (int i = 0; i < wr_log.size() && i < n; i++) begin
      if (wr_log[i].d != dst || wr_log[i].b !== pkt_q[i]) mism++;
    end
    chk("wr_data", mism, 0);
    chk("wr_onehot", oh_viol, 0);
    chk("done_count", done_n, 1);
    chk("done_time", done_at, last_acc + 1);
    chk("parity_err", done_perr, perr);
    chk("drop_err", done_derr, !vd);
    chk("flag_hold", {parity_err, drop_err}, {perr, !vd});
    chk("lfd_count", lfd_n, vd ? 1 : 0);
    if (vd) chk("lfd_byte", lfd_byte, hdr);
    if (vd && !perr) exp_good = (exp_good < 65535) ? exp_good + 1 : exp_good;
    else             exp_bad  = (exp_bad  < 65535) ? exp_bad  + 1 : exp_bad;
`ifdef ROUTER_PKT_STATS_EN
    chk("pkt_count", pkt_count, exp_good);
    chk("err_count", err_count, exp_bad);
`else
    chk("pkt_count", pkt_count, 0);
    chk("err_count", err_count, 0);
`endif
  endtask

  // Source that obeys busy, with random idle gaps and random FIFO-full flags.
  task automatic send_pkt(input int gap_pct, input int full_pct);
    int         idx;
    int         start;
    int         dst;
    logic       v;
    logic [2:0] f;
    logic [7:0] hdr;
    clear_mon();
    idx   = 0;
    start = cyc_n;
    hdr   = pkt_q[0];
    dst   = int'(hdr[1:0]);
    while (idx < pkt_q.size() && (cyc_n - start) < 4000) begin
      v = ($urandom_range(99) >= gap_pct);
      f = 3'b000;
      for (int i = 0; i < 3; i++) if ($urandom_range(99) < full_pct) f[i] = 1'b1;
      cyc(v, pkt_q[idx], f);
      if (v) chk("busy", busy, (dst < 3) ? f[dst] : 1'b0);
      if (acc) idx++;
    end
    if (idx < pkt_q.size()) chk("timeout", idx, pkt_q.size());
    verify();
  endtask

  task automatic chk_reset_state();
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_lfd", lfd_state, 0);
    chk("rst_done", pkt_done, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_derr", drop_err, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_err_count", err_count, 0);
  endtask

  initial begin
    rst_req = 1'b1;
    cyc(1'b0, 8'h00, 3'b000);
    cyc(1'b0, 8'h00, 3'b000);
    chk_reset_state();
    rst_req = 1'b0;

    // Good packet to dest 1, back-to-back
    pkt_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    send_pkt(0, 0);

    // Bad parity to dest 0
    pkt_q = '{8'h08, 8'hAA, 8'h55, 8'h00};
    send_pkt(0, 0);

    // Back-pressure on dest 2 after the first payload byte
    pkt_q = '{8'h0A, 8'h5C, 8'hA7, 8'hF1};
    clear_mon();
    cyc(1'b1, 8'h0A, 3'b000);
    cyc(1'b1, 8'h5C, 3'b000);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'hA7, 3'b100);
      chk("bp_busy", busy, 1);
      chk("bp_wr_en", wr_en, 0);
    end
    cyc(1'b1, 8'hA7, 3'b000);
    chk("bp_release", wr_en, 3'b100);
    cyc(1'b1, 8'hF1, 3'b000);
    verify();

    // Invalid destination, then a normal packet
    pkt_q = '{8'h0B, 8'h01, 8'h02, 8'h09};
    send_pkt(0, 0);
    gen_pkt(1, 4, 1'b0);
    send_pkt(0, 0);

    // Zero length with gaps
    pkt_q = '{8'h00, 8'h00};
    send_pkt(60, 0);

    // Reset mid-packet with error flag set beforehand
    gen_pkt(2, 3, 1'b1);
    send_pkt(0, 0);
    clear_mon();
    cyc(1'b1, 8'h14, 3'b000);
    cyc(1'b1, 8'h3C, 3'b000);
    cyc(1'b1, 8'hC3, 3'b000);
    rst_req = 1'b1;
    cyc(1'b0, 8'h00, 3'b000);
    rst_req = 1'b0;
    cyc(1'b0, 8'h00, 3'b000);
    chk_reset_state();
    chk("rst_writes", wr_log.size(), 3);
    exp_good = 0;
    exp_bad  = 0;
    gen_pkt(0, 5, 1'b0);
    send_pkt(0, 0);

    // Randomized packets including maximum length
    for (int k = 0; k < 40; k++) begin
      gen_pkt((k == 1) ? 3 : $urandom_range(3),
              (k < 2) ? 63 : $urandom_range(63),
              ($urandom_range(3) == 0));
      send_pkt(30, 25);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
